// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Operands are latched as magnitudes, an unsigned core runs, and the sign is applied on completion.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Stall
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [2:0]      op_q;
  logic            signA_q, signB_q, divZero_q, done_q;
  logic [W-1:0]    magA_q, magB_q, hi_q, lo_q, result_q;
  logic [W-1:0]    hi_d, lo_d, result_d;

  logic            signedA, signedB, negA, negB, divByZero;
  logic [W-1:0]    magA, magB;

  always_comb begin
    signedA   = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                (Funct3 == 3'b100) || (Funct3 == 3'b110);
    signedB   = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    negA      = signedA && SrcA[W-1];
    negB      = signedB && SrcB[W-1];
    magA      = negA ? -SrcA : SrcA;
    magB      = negB ? -SrcB : SrcB;
    divByZero = Funct3[2] && (SrcB == '0);
  end

  // hi/lo hold {partial product, multiplier} for multiply, {remainder, dividend->quotient} for divide
  logic [W:0] addSum, trial, diff;
  always_comb begin
    addSum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? magA_q : {W{1'b0}})};
    trial  = {hi_q, lo_q[W-1]};
    diff   = trial - {1'b0, magB_q};
    if (op_q[2]) begin
      if (!diff[W]) begin
        hi_d = diff[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = trial[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      hi_d = addSum[W:1];
      lo_d = {addSum[0], lo_q[W-1:1]};
    end
  end

  logic [2*W-1:0] prod, prodSigned;
  logic [W-1:0]   quot, rem;
  always_comb begin
    prod       = {hi_q, lo_q};
    prodSigned = (signA_q ^ signB_q) ? -prod : prod;
    quot       = divZero_q ? lo_q : ((signA_q ^ signB_q) ? -lo_q : lo_q);
    rem        = signA_q ? -hi_q : hi_q;
    case (op_q)
      3'b000:                 result_d = prodSigned[W-1:0];
      3'b001, 3'b010, 3'b011: result_d = prodSigned[2*W-1:W];
      3'b100, 3'b101:         result_d = quot;
      default:                result_d = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      done_q    <= 1'b0;
      magA_q    <= '0;
      magB_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= Funct3;
            signA_q   <= negA;
            signB_q   <= negB;
            magA_q    <= magA;
            magB_q    <= magB;
            divZero_q <= divByZero;
            count_q   <= '0;
            // Divide by zero skips the core: quotient all ones, remainder is the dividend
            if (divByZero) begin
              hi_q    <= magA;
              lo_q    <= '1;
              state_q <= DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= Funct3[2] ? magA : magB;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) state_q <= DONE;
        end
        DONE: begin
          done_q   <= 1'b1;
          result_q <= result_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == CALC);
  assign Stall  = ((state_q == IDLE) && start) || (state_q == CALC);
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        busy, done, Stall;
  logic [31:0] Result;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
    .Result(Result), .Stall(Stall)
  );

  always #5 clk = ~clk;

  // RV32M semantics straight from the ISA rules, using 64-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op from the current time and returns #1 after the edge on which done appears
  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
    int k, busyCnt, profileBad, expLat, expBusy;
    logic [31:0] exp;
    exp     = refModel(f, a, b);
    expLat  = (f[2] && b == 0) ? 1 : 33;
    expBusy = (f[2] && b == 0) ? 0 : 32;
    Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++; $display("[TB] FAIL %s stall_on_start: got %b want 1", name, Stall);
    end
    @(posedge clk); #1;
    start = 1'b0; Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    k = 0; busyCnt = 0; profileBad = 0;
    while (done !== 1'b1 && k < 100) begin
      if (busy === 1'b1) busyCnt++;
      if (Stall !== busy) profileBad++;
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (done !== 1'b1 || k != expLat) begin
      fails++; $display("[TB] FAIL %s latency: got %0d done=%b want %0d", name, k, done, expLat);
    end
    tests++;
    if (Result !== exp) begin
      fails++; $display("[TB] FAIL %s result: got %h want %h", name, Result, exp);
    end
    tests++;
    if (busyCnt != expBusy) begin
      fails++; $display("[TB] FAIL %s busy_cycles: got %0d want %0d", name, busyCnt, expBusy);
    end
    tests++;
    if (profileBad != 0 || Stall !== 1'b0) begin
      fails++; $display("[TB] FAIL %s stall_profile: got %0d bad cycles, stall_at_done=%b want 0/0", name, profileBad, Stall);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    tests++; if (Result !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h want 0", Result); end
    tests++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b want 0", Stall); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    runOp(3'd0, 32'd7, 32'd6, "mul_7x6");
    @(posedge clk); #1;
    runOp(3'd1, 32'hFFFFFFFD, 32'd5, "mulh");
    runOp(3'd3, 32'hFFFFFFFD, 32'd5, "mulhu");
    runOp(3'd2, 32'hFFFFFFFF, 32'd2, "mulhsu");
    runOp(3'd4, 32'hFFFFFFF9, 32'd2, "div_neg");
    runOp(3'd6, 32'hFFFFFFF9, 32'd2, "rem_neg");
    runOp(3'd5, 32'd100, 32'd7, "divu");
    runOp(3'd7, 32'd100, 32'd7, "remu");
    runOp(3'd0, 32'd0, 32'h12345678, "mul_zero");
  endtask

  task automatic test_boundaries();
    runOp(3'd5, 32'h1234, 32'd0, "divu_by_zero");
    runOp(3'd6, 32'hFFFFFFF0, 32'd0, "rem_by_zero");
    runOp(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
    runOp(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_overflow");
    runOp(3'd4, 32'h80000000, 32'd0, "div_min_by_zero");
  endtask

  task automatic test_back_to_back();
    runOp(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_first");
    runOp(3'd7, 32'hDEADBEEF, 32'd17, "b2b_second");
    runOp(3'd4, 32'd5, 32'd0, "b2b_divzero");
    runOp(3'd1, 32'h80000000, 32'h80000000, "b2b_mulh_min");
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      runOp(f, a, b, $sformatf("rand%0d_f%0d", i, f));
    end
  endtask

  task automatic test_ignore_start();
    int k;
    @(posedge clk); #1;
    Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      if (k == 5) begin
        Funct3 = 3'd5; SrcA = 32'd9; SrcB = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || k != 33) begin
      fails++; $display("[TB] FAIL ignore_start_latency: got %0d done=%b want 33", k, done);
    end
    tests++;
    if (Result !== 32'd9) begin
      fails++; $display("[TB] FAIL ignore_start_result: got %h want 9", Result);
    end
  endtask

  task automatic test_reset_abort();
    int doneSeen;
    @(posedge clk); #1;
    Funct3 = 3'd0; SrcA = 32'd11; SrcB = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    tests++; if (Stall !== 1'b0) begin fails++; $display("[TB] FAIL abort_stall: got %b want 0", Stall); end
    tests++; if (Result !== 32'h0) begin fails++; $display("[TB] FAIL abort_result: got %h want 0", Result); end
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneSeen++;
      @(posedge clk); #1;
    end
    tests++;
    if (doneSeen != 0) begin
      fails++; $display("[TB] FAIL abort_no_done: got %0d done cycles want 0", doneSeen);
    end
    runOp(3'd0, 32'd2, 32'd2, "mul_after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_ignore_start();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
